// File: rtl/io_hub_pkg.sv
// Shared constants and types for the multi-port I/O hub and its UART serializer.
package io_hub_pkg;

    localparam int unsigned IO_LED_BIT       = 0;
    localparam int unsigned IO_UART_DATA_BIT = 1;
    localparam int unsigned IO_UART_STAT_BIT = 2;
    localparam int unsigned IO_HALT_BIT      = 3;

    localparam int unsigned ST_BUSY      = 9;
    localparam int unsigned ST_IDLE      = 10;
    localparam int unsigned ST_OVF       = 11;
    localparam int unsigned ST_COUNT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_e;

endpackage

// File: rtl/io_uart_hub_if.sv
// CPU I/O write/read channels for all ports, one 32-bit lane per port.
interface io_uart_hub_if #(
    parameter int unsigned NPORTS = 2
);
    logic [NPORTS-1:0]    io_wr;
    logic [32*NPORTS-1:0] io_addr;
    logic [32*NPORTS-1:0] io_wdata;
    logic [32*NPORTS-1:0] io_rdata;

    modport master (
        output io_wr,
        output io_addr,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_wr,
        input  io_addr,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/uart_tx_ser.sv
// 8N1 UART serializer: accepts a byte when idle, holds each bit for DIV cycles.
module uart_tx_ser
    import io_hub_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready_c,
    output logic       tx
);

    localparam int unsigned TW = $clog2(DIV);

    ser_state_e    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shf_q, shf_d;
    logic          tx_d;
    logic          tmr_end_c;

    assign tmr_end_c = (tmr_q == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shf_q   <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shf_q   <= shf_d;
            tx      <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q + TW'(1);
        bit_d      = bit_q;
        shf_d      = shf_q;
        tx_d       = tx;
        in_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                tmr_d      = '0;
                if (in_valid) begin
                    shf_d   = in_data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tmr_end_c) begin
                    tmr_d   = '0;
                    tx_d    = shf_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                // shift register always presents the current bit at [0]
                if (tmr_end_c) begin
                    tmr_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shf_d = shf_q >> 1;
                        tx_d  = shf_q[1];
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tmr_end_c) begin
                    tmr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/io_uart_hub.sv
// Merges NPORTS CPU I/O channels into LED/halt registers and a shared buffered UART TX.
module io_uart_hub
    import io_hub_pkg::*;
#(
    parameter int unsigned NPORTS      = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic          clk,
    input  logic          reset,
    io_uart_hub_if.slave  bus,
    output logic [7:0]    leds,
    output logic          halt,
    output logic          uart_tx
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [NPORTS-1:0] sel_led_c, sel_data_c, sel_stat_c, sel_halt_c;
    logic [NPORTS-1:0] wr_data_c, wr_stat_c, accept_c;
    logic [NPORTS-1:0] pend_vld, ovf;
    logic [7:0]        pend_data [NPORTS];
    logic [PTR_W-1:0]  rr_ptr;
    logic              gnt_vld_c;
    logic [PTR_W-1:0]  gnt_idx_c;
    logic [NPORTS-1:0] gnt_oh_c;
    int unsigned       scan;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full_c, fifo_nempty_c, push_c, pop_c;
    logic              ser_ready_c, tx_idle_c;
    logic [7:0]        led_d_c;
    logic              led_we_c;
    logic              unused_c;

    // Per-port word decode; address bits outside [5:2] and data above [7:0] are don't-care
    always_comb begin
        unused_c = 1'b0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            sel_led_c[i]  = bus.io_addr[32*i + 2 + IO_LED_BIT];
            sel_data_c[i] = bus.io_addr[32*i + 2 + IO_UART_DATA_BIT];
            sel_stat_c[i] = bus.io_addr[32*i + 2 + IO_UART_STAT_BIT];
            sel_halt_c[i] = bus.io_addr[32*i + 2 + IO_HALT_BIT];
            unused_c ^= ^{bus.io_addr[32*i + 6 +: 26], bus.io_addr[32*i +: 2],
                          bus.io_wdata[32*i + 8 +: 24]};
        end
    end

    assign wr_data_c = bus.io_wr & sel_data_c;
    assign wr_stat_c = bus.io_wr & sel_stat_c;
    assign accept_c  = wr_data_c & (~pend_vld | gnt_oh_c);

    // Round-robin: first occupied slot at or after rr_ptr, only while the FIFO has room
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        gnt_oh_c  = '0;
        scan      = 0;
        if (!fifo_full_c) begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                scan = 32'(rr_ptr) + k;
                if (scan >= NPORTS) scan = scan - NPORTS;
                if (!gnt_vld_c && pend_vld[PTR_W'(scan)]) begin
                    gnt_vld_c = 1'b1;
                    gnt_idx_c = PTR_W'(scan);
                end
            end
        end
        gnt_oh_c[gnt_idx_c] = gnt_vld_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld <= '0;
            ovf      <= '0;
            rr_ptr   <= '0;
        end else begin
            for (int i = 0; i < int'(NPORTS); i++) begin
                if (accept_c[i])      pend_vld[i] <= 1'b1;
                else if (gnt_oh_c[i]) pend_vld[i] <= 1'b0;
                // a dropped write sets the flag even if software clears it this cycle
                if (wr_data_c[i] && !accept_c[i]) ovf[i] <= 1'b1;
                else if (wr_stat_c[i])             ovf[i] <= 1'b0;
            end
            if (gnt_vld_c)
                rr_ptr <= (gnt_idx_c == PTR_W'(NPORTS - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NPORTS); i++)
            if (accept_c[i]) pend_data[i] <= bus.io_wdata[32*i +: 8];
    end

    // TX FIFO
    assign fifo_full_c   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_nempty_c = (fifo_cnt != '0);
    assign push_c        = gnt_vld_c;
    assign pop_c         = ser_ready_c && fifo_nempty_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_c, pop_c})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= pend_data[gnt_idx_c];
    end

    uart_tx_ser #(
        .DIV (DIV)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (fifo_nempty_c),
        .in_data    (fifo_mem[rd_ptr]),
        .in_ready_c (ser_ready_c),
        .tx         (uart_tx)
    );

    // LED: lowest-indexed writer wins, so scan high to low
    always_comb begin
        led_d_c  = leds;
        led_we_c = 1'b0;
        for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
            if (bus.io_wr[i] && sel_led_c[i]) begin
                led_d_c  = bus.io_wdata[32*i +: 8];
                led_we_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= '0;
            halt <= 1'b0;
        end else begin
            if (led_we_c) leds <= led_d_c;
            if (|(bus.io_wr & sel_halt_c)) halt <= 1'b1;
        end
    end

    assign tx_idle_c = !fifo_nempty_c && !(|pend_vld) && ser_ready_c;

    // Status word; every non-status read returns zero
    always_comb begin
        logic [31:0] st;
        bus.io_rdata = '0;
        st           = '0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            st                         = '0;
            st[ST_BUSY]                = pend_vld[i] | fifo_full_c;
            st[ST_IDLE]                = tx_idle_c;
            st[ST_OVF]                 = ovf[i];
            st[ST_COUNT_LSB +: CNT_W]  = fifo_cnt;
            if (sel_stat_c[i]) bus.io_rdata[32*i +: 32] = st;
        end
    end

endmodule

// File: tb/tb_io_uart_hub.sv
// Directed bench for io_uart_hub: DIV=10, two ports, 4-entry FIFO, serial line decoded by a monitor.
module tb_io_uart_hub;

    logic       clk;
    logic       reset;
    logic [7:0] leds;
    logic       halt;
    logic       uart_tx;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [9:0] rxq [$];

    io_uart_hub_if #(.NPORTS(2)) bus ();

    io_uart_hub #(
        .NPORTS      (2),
        .FIFO_DEPTH  (4),
        .CLK_FREQ_HZ (10),
        .BAUD_RATE   (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .leds    (leds),
        .halt    (halt),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_cycle(input logic [1:0] wr, input logic [31:0] a0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        bus.io_wr    = wr;
        bus.io_addr  = {a1, a0};
        bus.io_wdata = {d1, d0};
        @(posedge clk);
        #1;
        bus.io_wr = '0;
    endtask

    task automatic rd(input int p, input logic [31:0] a, output logic [31:0] v);
        bus.io_addr[32*p +: 32] = a;
        #1;
        v = bus.io_rdata[32*p +: 32];
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (rxq.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (rxq.size() < n) check("rx_timeout", 32'(rxq.size()), 32'(n));
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] b);
        logic [31:0] got;
        if (rxq.size() == 0) got = '1;
        else                 got = 32'(rxq.pop_front());
        check(tag, got, 32'({1'b1, b, 1'b0}));
    endtask

    // Line monitor: samples start, data and stop bits at their centres
    initial begin
        logic [9:0] fr;
        forever begin
            @(negedge clk);
            if (uart_tx == 1'b0) begin
                repeat (5) @(negedge clk);
                fr[0] = uart_tx;
                for (int j = 1; j <= 9; j++) begin
                    repeat (10) @(negedge clk);
                    fr[j] = uart_tx;
                end
                rxq.push_back(fr);
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  pat;
        logic        exp_b;
        int          nbad;

        reset        = 1'b1;
        bus.io_wr    = '0;
        bus.io_addr  = '0;
        bus.io_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_halt", 32'(halt), 32'h0);
        check("rst_tx", 32'(uart_tx), 32'h1);
        rd(0, 32'h10, v); check("rst_stat0", v, 32'h0000_0400);
        rd(1, 32'h10, v); check("rst_stat1", v, 32'h0000_0400);
        rd(0, 32'h04, v); check("nonstat_rd", v, 32'h0);

        // Collision with rr_ptr=0: port0 first, then port1
        bus_cycle(2'b11, 32'h08, 32'h41, 32'h08, 32'h42);
        rd(1, 32'h10, v); check("coll_stat1", v, 32'h0000_0200);
        wait_frames(2, 400);
        expect_rx("coll1_a", 8'h41);
        expect_rx("coll1_b", 8'h42);
        repeat (12) @(negedge clk);

        // rr_ptr wrapped back to 0 after port1
        bus_cycle(2'b11, 32'h08, 32'h61, 32'h08, 32'h62);
        wait_frames(2, 400);
        expect_rx("coll2_a", 8'h61);
        expect_rx("coll2_b", 8'h62);
        repeat (12) @(negedge clk);

        // Single char, exact waveform: tx falls at edge t+2
        bus_cycle(2'b01, 32'h08, 32'h55, 32'h0, 32'h0);
        pat  = 8'h55;
        nbad = 0;
        for (int k = 0; k < 102; k++) begin
            @(negedge clk);
            if (k < 2)       exp_b = 1'b1;
            else if (k < 12) exp_b = 1'b0;
            else if (k < 92) exp_b = pat[(k - 12) / 10];
            else             exp_b = 1'b1;
            if (uart_tx !== exp_b) nbad++;
        end
        check("frame55_wave", 32'(nbad), 32'h0);
        @(negedge clk);
        rd(0, 32'h10, v); check("idle_after55", v, 32'h0000_0400);
        expect_rx("rx_55", 8'h55);

        // Backpressure: A5 starts the serializer, then 01..06; 06 is dropped
        bus_cycle(2'b01, 32'h08, 32'hA5, 32'h0, 32'h0);
        for (int b = 1; b <= 6; b++)
            bus_cycle(2'b01, 32'h08, 32'(b), 32'h0, 32'h0);
        rd(0, 32'h10, v); check("bp_stat0", v, 32'h0004_0A00);
        rd(1, 32'h10, v); check("bp_stat1", v, 32'h0004_0200);
        bus_cycle(2'b01, 32'h10, 32'h0, 32'h0, 32'h0);
        rd(0, 32'h10, v); check("bp_ovf_clr", v, 32'h0004_0200);
        wait_frames(6, 1000);
        expect_rx("bp_a5", 8'hA5);
        for (int b = 1; b <= 5; b++)
            expect_rx("bp_byte", 8'(b));
        repeat (150) @(negedge clk);
        check("bp_no_extra", 32'(rxq.size()), 32'h0);

        // LED priority and sticky halt
        bus_cycle(2'b11, 32'h04, 32'h11, 32'h04, 32'h22);
        check("led_prio", 32'(leds), 32'h11);
        bus_cycle(2'b10, 32'h0, 32'h0, 32'h04, 32'h33);
        check("led_p1", 32'(leds), 32'h33);
        check("halt_pre", 32'(halt), 32'h0);
        bus_cycle(2'b10, 32'h0, 32'h0, 32'h20, 32'h0);
        check("halt_set", 32'(halt), 32'h1);
        repeat (5) @(negedge clk);
        check("halt_sticky", 32'(halt), 32'h1);

        // Reset during DATA bit 3 aborts the frame
        bus_cycle(2'b01, 32'h08, 32'hC3, 32'h0, 32'h0);
        repeat (46) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_tx", 32'(uart_tx), 32'h1);
        rd(0, 32'h10, v); check("mid_rst_stat", v, 32'h0000_0400);
        check("mid_rst_halt", 32'(halt), 32'h0);
        check("mid_rst_leds", 32'(leds), 32'h0);
        repeat (120) @(negedge clk);
        rxq.delete();
        bus_cycle(2'b01, 32'h08, 32'h3C, 32'h0, 32'h0);
        wait_frames(1, 300);
        expect_rx("post_rst_3c", 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
